pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width in bits (4..32).
REQ-003 SHALL have parameter RESET_DATA, default 0, DATA_W-bit value loaded into payload registers on reset.
REQ-004 SHALL use one clock and a synchronous, active-low reset, named as the codebase does: CLK (input, 1) and RSTn (input, 1), all state sampled on rising CLK.
REQ-005 SHALL have port CLK  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port RSTn  input  1  synchronous active-low reset.
REQ-007 SHALL have port flush  input  1  discard all held entries.
REQ-008 SHALL have port in_valid  input  1  upstream presents payload.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-011 SHALL have port out_valid  output  1  stage presents payload.
REQ-012 SHALL have port out_data  output  DATA_W  payload to downstream.
REQ-013 SHALL have port out_ready  input  1  downstream accepts payload.
REQ-014 SHALL have port occupancy  output  2  entries held (0..1 base, 0..2 with skid).
REQ-015 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL accept a payload only on a cycle with in_valid=1 and in_ready=1, and deliver one only on a cycle with out_valid=1 and out_ready=1.
REQ-017 SHALL present an accepted payload on out_data with out_valid=1 exactly 1 cycle after acceptance when the stage was empty.
REQ-018 SHALL preserve payload order, and never drop or duplicate a payload except on flush.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, in base mode, hold one entry, with in_ready = RSTn && (!out_valid || out_ready) combinationally, so accept and deliver occur on the same cycle when full with out_ready=1.
REQ-021 SHALL, on flush=1, clear every valid bit on the next edge, discard any payload accepted that cycle, and leave payload registers unchanged.
REQ-022 SHALL give flush priority over simultaneous accept and deliver; a delivery on the flush cycle still counts as completed downstream.
REQ-023 SHALL increment stall_cnt by 1 on each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and clear it only on reset.
REQ-024 SHALL report occupancy as the number of valid entries after the current edge, registered.

Reset
REQ-025 SHALL, while RSTn=0 at a rising edge, clear all valid bits, load RESET_DATA into every payload register, and clear stall_cnt and occupancy to 0.
REQ-026 SHALL drive in_ready=0 in any cycle where RSTn=0, and in_ready=1 on the first cycle after release.
REQ-027 SHALL discard in-flight payloads when reset is asserted mid-transfer, with no delivery after release until new data is accepted.

Configuration
REQ-028 SHALL, with macro PIPE_STAGE_REG_SKID_EN defined, add a second (skid) entry and drive in_ready from a register as RSTn && !skid_valid, with no combinational path from out_ready.
REQ-029 SHALL, with PIPE_STAGE_REG_SKID_EN defined, place data accepted while the main entry is stalled into the skid entry, and move it to the main entry on the edge the main entry is delivered.
REQ-030 SHALL, without PIPE_STAGE_REG_SKID_EN, implement base mode only, with occupancy never exceeding 1.

Verification
REQ-031 SHALL pass: reset, in_valid=1, in_data=0xA5A5A5A5, out_ready=1 -> out_valid=1, out_data=0xA5A5A5A5 one cycle later, and occupancy=1.
REQ-032 SHALL pass: stream 0x1..0x8 back-to-back with out_ready=1 -> 0x1..0x8 delivered in order on consecutive cycles, and stall_cnt=0.
REQ-033 SHALL pass: hold out_ready=0 for 5 cycles while full -> out_data stable and stall_cnt=5; with skid, second word 0x2 held and occupancy=2, in_ready=0.
REQ-034 SHALL pass: flush=1 with in_valid=1, in_data=0x77 while full -> next cycle out_valid=0, occupancy=0, and 0x77 never delivered.
REQ-035 SHALL pass: CNT_W=4 with a 20-cycle stall -> stall_cnt saturates at 0xF.
REQ-036 SHALL pass: RSTn=0 mid-stream with occupancy=2 -> next cycle out_valid=0, out_data=RESET_DATA, in_ready=0 during reset, and in_ready=1 after release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with stall counter and flush.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry and register-driven in_ready.
module pipe_stage_reg #(
    parameter int                DATA_W     = 32,
    parameter int                CNT_W      = 16,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [1:0]        occupancy_q, occupancy_d;
    logic              accept;
    logic              deliver;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // in_ready depends only on RSTn and a flop, so out_ready never reaches upstream
    assign in_ready = RSTn && !skid_valid_q;
`else
    assign in_ready = RSTn && (!valid_q || out_ready);
`endif

    assign accept    = in_valid && in_ready;
    assign deliver   = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign occupancy = occupancy_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        stall_cnt_d = stall_cnt_q;
`ifdef PIPE_STAGE_REG_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (deliver) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
        // Main entry still busy after this edge: park the new word in the skid entry
        if (accept) begin
            if (!valid_d) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end
        occupancy_d = {1'b0, valid_d} + {1'b0, skid_valid_d};
`else
        if (deliver) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
        occupancy_d = {1'b0, valid_d};
`endif

        if (valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            valid_q      <= 1'b0;
            data_q       <= RESET_DATA;
            stall_cnt_q  <= '0;
            occupancy_q  <= 2'd0;
`ifdef PIPE_STAGE_REG_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_DATA;
`endif
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            stall_cnt_q  <= stall_cnt_d;
            occupancy_q  <= occupancy_d;
`ifdef PIPE_STAGE_REG_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, 32-bit and CNT_W=4 instances.
module tb_pipe_stage_reg;

    localparam logic [31:0] RD  = 32'hDEADBEEF;
    localparam logic [7:0]  RD4 = 8'h5A;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4;
    logic [7:0]  out_data4;
    logic [1:0]  occupancy4;
    logic [3:0]  stall_cnt4;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb[$];
    int unsigned stall_m  = 0;
    int unsigned stall4_m = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CNT_W(16), .RESET_DATA(RD)) u_dut (
        .CLK(clk), .RSTn(rstn), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CNT_W(4), .RESET_DATA(RD4)) u_dut4 (
        .CLK(clk), .RSTn(rstn), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
        .occupancy(occupancy4), .stall_cnt(stall_cnt4)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
        return rstn && (sb.size() < 2);
`else
        return rstn && ((sb.size() == 0) || out_ready);
`endif
    endfunction

    // Inputs are already applied; check outputs, then advance the model across one edge.
    task automatic cycle();
        bit rdy, acc, del;
        logic [31:0] head;
        #1;
        rdy = exp_ready();
        check_eq("in_ready", in_ready, rdy);
        check_eq("in_ready4", in_ready4, rdy);
        check_eq("out_valid", out_valid, sb.size() > 0);
        check_eq("out_valid4", out_valid4, sb.size() > 0);
        if (sb.size() > 0) begin
            head = sb[0];
            check_eq("out_data", out_data, head);
            check_eq("out_data4", out_data4, head[7:0]);
        end
        check_eq("occupancy", occupancy, sb.size());
        check_eq("occupancy4", occupancy4, sb.size());
        check_eq("stall_cnt", stall_cnt, stall_m);
        check_eq("stall_cnt4", stall_cnt4, stall4_m);
        acc = in_valid && rdy;
        del = (sb.size() > 0) && out_ready;
        @(posedge clk);
        if (!rstn) begin
            sb.delete();
            stall_m  = 0;
            stall4_m = 0;
        end else begin
            if ((sb.size() > 0) && !out_ready) begin
                if (stall_m < 32'h0000_FFFF) stall_m++;
                if (stall4_m < 15) stall4_m++;
            end
            if (del) void'(sb.pop_front());
            if (flush) sb.delete();
            else if (acc) sb.push_back(in_data);
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        rstn = 1'b1;
        #1;
        check_eq("reset_out_data", out_data, RD);
        check_eq("reset_out_data4", out_data4, RD4);
        check_eq("ready_after_release", in_ready, 1'b1);

        // Single word, one-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5A5A5;
        cycle();
        in_valid = 1'b0;
        #1;
        check_eq("single_valid", out_valid, 1'b1);
        check_eq("single_data", out_data, 32'hA5A5A5A5);
        check_eq("single_occ", occupancy, 2'd1);
        cycle();
        cycle();

        // Back-to-back stream
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();
        check_eq("stream_stall0", stall_cnt, 16'd0);

        // Five-cycle stall while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        cycle();
        in_data = 32'h2;
        repeat (5) cycle();
        check_eq("stall5", stall_cnt, 16'd5);
        check_eq("stall5_data", out_data, 32'h1);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();

        // Flush while full with a word offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        cycle();
        flush   = 1'b1;
        in_data = 32'h77;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("flush_valid", out_valid, 1'b0);
        check_eq("flush_occ", occupancy, 2'd0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Long stall saturates the 4-bit counter
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h99;
        cycle();
        in_valid = 1'b0;
        repeat (20) cycle();
        check_eq("sat4", stall_cnt4, 4'hF);
        out_ready = 1'b1;
        repeat (2) cycle();

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        cycle();
        in_data = 32'hB;
        cycle();
        rstn = 1'b0;
        cycle();
        #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_data", out_data, RD);
        check_eq("rst_ready", in_ready, 1'b0);
        cycle();
        rstn     = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
